// File: rtl/seq_shifter_if.sv
// Handshake/data bundle between the controller (master) and seq_shifter (slave).
// The cout signal exists only when SEQ_SHIFTER_COUT_EN is defined.
interface seq_shifter_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
`ifdef SEQ_SHIFTER_COUT_EN
    logic             cout;
`endif

    modport master (
        output start, mode, amt, din,
`ifdef SEQ_SHIFTER_COUT_EN
        input  cout,
`endif
        input  busy, done, dout
    );

    modport slave (
        input  start, mode, amt, din,
`ifdef SEQ_SHIFTER_COUT_EN
        output cout,
`endif
        output busy, done, dout
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle ROR/LSL/LSR/ASR shifter, one bit position per clock, start/busy/done handshake.
// Optional carry-out register enabled by defining SEQ_SHIFTER_COUT_EN.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_shifter_if.slave  bus
);
    localparam logic [1:0] M_ROR = 2'b00;
    localparam logic [1:0] M_LSL = 2'b01;
    localparam logic [1:0] M_LSR = 2'b10;
    localparam logic [1:0] M_ASR = 2'b11;
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [1:0]       r_mode;
    logic [AMT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_next;
    logic             w_clamp;
    logic [AMT_W-1:0] w_cnt_ld;

    assign w_clamp  = (bus.amt >= W_AMT);
    assign w_cnt_ld = w_clamp ? W_AMT : bus.amt;

    always_comb begin
        w_next = r_sh;
        case (r_mode)
            M_LSL:   w_next = {r_sh[WIDTH-2:0], 1'b0};
            M_LSR:   w_next = {1'b0, r_sh[WIDTH-1:1]};
            M_ASR:   w_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
            default: w_next = {r_sh[0], r_sh[WIDTH-1:1]};
        endcase
    end

`ifdef SEQ_SHIFTER_COUT_EN
    logic r_cout;
    logic r_clamp;
    logic w_out;
    logic w_kill;

    assign w_out  = (r_mode == M_LSL) ? r_sh[WIDTH-1] : r_sh[0];
    // A fully clamped logical shift has pushed out every bit; report no carry.
    assign w_kill = r_clamp && (r_mode == M_LSL || r_mode == M_LSR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cout  <= 1'b0;
            r_clamp <= 1'b0;
        end else if (r_state != S_SHIFT) begin
            if (bus.start) begin
                r_cout  <= 1'b0;
                r_clamp <= w_clamp;
            end
        end else begin
            r_cout <= w_out & ~w_kill;
        end
    end

    assign bus.cout = r_cout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_mode  <= M_ROR;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_sh   <= bus.din;
                        r_mode <= bus.mode;
                        r_cnt  <= w_cnt_ld;
                        if (w_cnt_ld != '0) begin
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_sh  <= w_next;
                    r_cnt <= r_cnt - AMT_W'(1);
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dout = r_sh;
endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shifter: the next-generation datapath shifter. It applies a logical-left, logical-right, arithmetic-right or rotate-right operation of a variable amount to a WIDTH-bit operand, one bit position per clock. A start/busy/done handshake lets the controller FSM launch an operation and wait for the result. It sits between the register-file read port and the ALU B input, replacing the fixed single-bit shifter on multi-bit shift instructions.

## Interface
- WIDTH, 16, operand/result width in bits; integer ≥ 2.
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount input.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- mode  in  2  00 ROR, 01 LSL, 10 LSR, 11 ASR; captured with start.
- amt  in  AMT_W  shift amount; captured with start.
- din  in  WIDTH  operand; captured with start.
- busy  out  1  high in SHIFT state.
- done  out  1  one-cycle pulse: result valid.
- dout  out  WIDTH  result; held stable from done until next accepted start.
- cout  out  1  last bit shifted/rotated out (only with SEQ_SHIFTER_COUT_EN).

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE, dout=0, busy=0, done=0, cout=0, count=0.
- IDLE or DONE with start=1: load shift register←din, mode reg←mode, count←min(amt, WIDTH); next state SHIFT if count≠0, else DONE.
- IDLE or DONE with start=0: DONE → IDLE; IDLE stays.
- SHIFT: each cycle shift one position per mode, count←count−1. When count reaches 0, next state is DONE.
  - LSL: {r[W-2:0],0}, out bit r[W-1].
  - LSR: {0,r[W-1:1]}, out bit r[0].
  - ASR: {r[W-1],r[W-1:1]}, out bit r[0].
  - ROR: {r[0],r[W-1:1]}, out bit r[0].
- start during SHIFT is ignored (no queueing). Inputs change freely while busy.
- amt ≥ WIDTH clamps to WIDTH:
  - LSL/LSR → 0.
  - ASR → all copies of din[W-1].
  - ROR → din unchanged.
- amt=0: dout=din, cout=0.
- dout is the shift register itself; it is only observable as valid from done onward.

## Timing
- Start sampled at edge N. With count=k>0: busy high for cycles N+1..N+k. done high in cycle N+k+1.
- amt=0: done high in cycle N+1, busy never asserted.
- Throughput: start may be asserted in the DONE cycle. It is accepted, and done of the new op follows with the same latency. Back-to-back ops therefore cost k+1 cycles each.
- rst_n low at any time, including mid-SHIFT: immediate asynchronous return to the reset state. The in-flight operation is discarded and no done is produced.
- Release of rst_n is synchronised externally. The first start is sampled on the first rising edge with rst_n=1.

## Configuration
- SEQ_SHIFTER_COUT_EN defined:
  - cout port exists.
  - Each SHIFT cycle registers the out bit. cout is valid with done and held with dout.
  - cout resets to 0 and is 0 for amt=0.
  - For clamped LSL/LSR, cout=0 once all bits are out.
- Undefined: cout port and its register are absent. All other behaviour is identical.

## Test plan
- Reset mid-op: WIDTH=16, start LSL din=16'h0001 amt=5, assert rst_n=0 at cycle N+3 → outputs 0 immediately, state IDLE, no done pulse.
- Latency: WIDTH=16, LSL din=16'h0001 amt=4 → busy cycles N+1..N+4, done at N+5, dout=16'h0010. With COUT_EN, cout=0.
- ASR sign fill: din=16'h8004 amt=3 → dout=16'hF000, cout=1 (COUT_EN). Repeat with LSR → dout=16'h1000.
- ROR and clamp:
  - din=16'hA5C3 ROR amt=4 → dout=16'h3A5C.
  - amt=16 → dout=16'hA5C3.
  - amt=31 LSL → dout=16'h0000.
  - amt=31 ASR with din=16'h8000 → dout=16'hFFFF.
- Zero amount and back-to-back:
  - amt=0 din=16'h1234 → done at N+1, busy never high, dout=16'h1234.
  - start held high in DONE with LSR din=16'h0100 amt=8 → accepted; done 9 cycles later, dout=16'h0001.
- Start ignored while busy: pulse start with different din at N+2 of a k=6 op → first result unaffected, no extra done.
